// File: rtl/sum_result_buffer.sv
// ============================================================================
// Module   : sum_result_buffer
// Purpose  : Captures the adder's y/valid result stream into a small FIFO and
//            presents it on a ready/valid interface. Counts dropped results
//            and keeps a sticky overflow flag.
// Options  : SUM_BUF_ACC_EN - implements the running accumulator on acc;
//            when undefined, acc is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_result_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CW-1:0]              drop_cnt,
  output logic [W+7:0]               acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;

  // A pop on a full FIFO frees the slot the incoming result needs.
  assign w_full = (level_q == C_FULL_LVL);
  assign w_pop  = (level_q != '0) && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (w_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through level_q.
  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef SUM_BUF_ACC_EN
  logic [W+7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (w_push) acc_d = acc_q + {8'd0, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
`else
  assign acc = '0;
`endif

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: doc/sum_result_buffer.md
Name: sum_result_buffer

Overview:
- Downstream consumer of the adder stage's y/valid result stream.
- The adder has no backpressure, so this block captures each valid result into a small FIFO and presents it on a ready/valid output interface.
- Counts results dropped on overflow and keeps a sticky overflow flag.
- Optionally keeps a running accumulation of all accepted results.

Parameters:
- W, 16, result data width; must match the upstream adder's W.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CW, 8, width of the drop counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  result strobe from the adder stage (its valid); one-cycle pulses, no backpressure.
- in_data  input  W  result value from the adder stage (its y); sampled only when in_valid=1.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  downstream accepts the head this cycle.
- out_data  output  W  FIFO head value.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: set when any result was dropped.
- drop_cnt  output  CW  number of dropped results, saturating.
- acc  output  W+8  running sum of accepted results (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; sampled on posedge clk.
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, acc=0. Read/write pointers=0. out_data is don't-care while out_valid=0.
- Reset mid-operation:
  - All stored entries are discarded on the reset edge.
  - in_valid during reset is ignored; nothing is counted or accumulated.
- Pop: pop = out_valid && out_ready.
- Push: push = in_valid && (level<DEPTH || pop).
  - When full, a simultaneous pop frees a slot, so the incoming result is accepted.
- Drop: drop = in_valid && level==DEPTH && !pop.
  - A dropped value is not written.
  - overflow<=1 and stays set until reset.
  - drop_cnt increments by 1 and saturates at 2^CW-1 (no wrap).
- Occupancy: level next = level + push - pop. Push and pop together leave level unchanged.
- Latency:
  - A result pushed at edge N gives out_valid=1 with that data after edge N. It is visible to downstream in cycle N+1; no same-cycle bypass.
  - The push into an empty FIFO takes one cycle to appear at the head.
- Output interface:
  - out_valid = (level!=0), registered-derived.
  - out_data = mem[rd_ptr].
  - out_data must stay stable while out_valid=1 && out_ready=0.
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- Empty FIFO: out_ready with level==0 has no effect; no underflow.
- Arithmetic: acc next = acc + zero-extended in_data on every push. It wraps modulo 2^(W+8); dropped values are excluded.
- Assertion properties the bench must check:
  - out_valid==0 in the cycle after reset.
  - level never exceeds DEPTH.
  - out_data stable under stall.
  - drop_cnt never decreases.

Optional Feature:
- Macro: SUM_BUF_ACC_EN.
- Defined: acc register implemented as described above.
- Undefined: no accumulator register; acc port is driven constant 0. FIFO, drop counter and overflow behaviour are unchanged.

Test Plan:
- Basic pass-through:
  - Stimulus: reset 3 cycles, then in_valid pulse with in_data=0x0123, out_ready=1.
  - Response: next cycle out_valid=1, out_data=0x0123, level=1; the following cycle level=0, out_valid=0.
- Fill and order:
  - Stimulus: out_ready=0; push 0x0001, 0x0002, 0x0003, 0x0004; then out_ready=1.
  - Response: level=4; pops return 1,2,3,4 in order; out_data holds 0x0001 through the stall.
- Overflow:
  - Stimulus: full (4 entries), out_ready=0, push 0x00AA then 0x00BB.
  - Response: both dropped; overflow=1, drop_cnt=2, level=4; head still 0x0001.
- Full with simultaneous push/pop:
  - Stimulus: level=4, out_ready=1, in_valid with 0x0055 in the same cycle.
  - Response: level stays 4, drop_cnt unchanged, 0x0055 emerges last.
- Accumulator (SUM_BUF_ACC_EN defined):
  - Stimulus: accept 0x07FE and 0x0401.
  - Response: acc=0x000BFF; after 300 pushes of 0xFFFF, acc wraps modulo 2^24. With the macro undefined, acc=0 throughout.
- Reset mid-stream:
  - Stimulus: level=3, overflow=1; assert rst for 1 cycle with in_valid=1.
  - Response: level=0, out_valid=0, overflow=0, drop_cnt=0, acc=0; the in_valid value during reset is not stored.
